alu_seq: RTL and testbench

- Registered, handshaked successor to the combinational CPU ALU: parametrised width, full 3-bit opcode space and a multi-cycle iterative multiply.
- Sits between the decode/register-read stage and writeback; holds its result until the consumer accepts it.
- Produces registered Zero/Sign/Carry flags alongside the result.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 130 +++++++++++++
 tb/tb_alu_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-read stage, alu_seq and writeback.
// The master drives operands and consumes results; alu_seq sits on the slave side.
interface alu_seq_if #(
    parameter int W   = 8,
    parameter int Ops = 3
);
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [Ops-1:0] OP;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out;
    logic           Zero;
    logic           Sign;
    logic           Carry;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output A, B, OP, in_valid, out_ready,
        input  in_ready, out, Zero, Sign, Carry, out_valid
    );

    modport slave (
        input  A, B, OP, in_valid, out_ready,
        output in_ready, out, Zero, Sign, Carry, out_valid
    );
endinterface

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle ADD/SUB/shift/logic ops and a
// W-cycle shift-add multiply, holding each result until writeback accepts it.
module alu_seq #(
    parameter int W   = 8,
    parameter int Ops = 3
) (
    input logic       Clk,
    input logic       Reset,
    alu_seq_if.slave  bus
);
    localparam int SW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_inReady;
    logic             w_outValid;
    logic             w_lastIter;

    logic [W-1:0]     r_out;
    logic             r_carry;
    logic [2*W-1:0]   r_acc;
    logic [2*W-1:0]   r_mcand;
    logic [W-1:0]     r_mplier;
    logic [SW-1:0]    r_cnt;

    logic [W:0]       w_sum;
    logic [W:0]       w_srlBits;
    logic [W:0]       w_sllBits;
    logic [W-1:0]     w_result;
    logic             w_carry;
    logic             w_isMul;
    logic [2*W-1:0]   w_accNext;

    assign w_isMul    = (bus.OP == Ops'(3'b111));
    assign w_lastIter = (r_cnt == SW'(W - 1));

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_inReady  = 1'b0;
        w_outValid = 1'b0;
        case (r_state)
            IDLE: begin
                w_inReady = 1'b1;
                if (bus.in_valid) w_next = w_isMul ? BUSY : DONE;
            end
            BUSY: begin
                if (w_lastIter) w_next = DONE;
            end
            DONE: begin
                w_outValid = 1'b1;
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Shifting a guard bit alongside A lets the shifter itself produce the
    // last bit shifted out; amounts above W naturally flush everything to 0.
    always_comb begin
        w_sum     = {1'b0, bus.A} + {1'b0, bus.B};
        w_srlBits = {bus.A, 1'b0} >> bus.B;
        w_sllBits = {1'b0, bus.A} << bus.B;
        w_result  = '0;
        w_carry   = 1'b0;
        case (bus.OP)
            3'b000: begin w_result = w_sum[W-1:0];      w_carry = w_sum[W];         end
            3'b001: begin w_result = w_srlBits[W:1];    w_carry = w_srlBits[0];     end
            3'b010: begin w_result = w_sllBits[W-1:0];  w_carry = w_sllBits[W];     end
            3'b011: begin w_result = bus.A ^ bus.B;                                 end
            3'b100: begin w_result = bus.A - bus.B;     w_carry = (bus.A < bus.B);  end
            3'b101: begin w_result = bus.A & bus.B;                                 end
            3'b110: begin w_result = bus.A | bus.B;                                 end
            default: begin w_result = '0;               w_carry = 1'b0;             end
        endcase
    end

    assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_out    <= '0;
            r_carry  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (w_isMul) begin
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_mcand  <= {{W{1'b0}}, bus.A};
                            r_mplier <= bus.B;
                        end else begin
                            r_out   <= w_result;
                            r_carry <= w_carry;
                        end
                    end
                end
                BUSY: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + SW'(1);
                    if (w_lastIter) begin
                        r_out   <= w_accNext[W-1:0];
                        r_carry <= |w_accNext[2*W-1:W];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.out       = r_out;
    assign bus.Carry     = r_carry;
    assign bus.Zero      = (r_out == '0);
    assign bus.Sign      = r_out[W-1];
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases followed by random
// operations, all compared against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.W(W), .Ops(3)) bus ();

    alu_seq #(.W(W), .Ops(3)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference results from plain integer arithmetic on the op definitions.
    function automatic void refModel(input logic [2:0] op, input int a, input int b,
                                     output int res, output int carry);
        int modv;
        int full;
        modv  = 1 << W;
        full  = 0;
        res   = 0;
        carry = 0;
        case (op)
            3'd0: begin full = a + b; res = full % modv; carry = int'(full >= modv); end
            3'd1: begin
                res   = (b >= W) ? 0 : (a >> b);
                carry = (b >= 1 && b <= W) ? ((a >> (b - 1)) & 1) : 0;
            end
            3'd2: begin
                res   = (b >= W) ? 0 : ((a << b) % modv);
                carry = (b >= 1 && b <= W) ? ((a >> (W - b)) & 1) : 0;
            end
            3'd3: res = a ^ b;
            3'd4: begin res = (a - b + modv) % modv; carry = int'(a < b); end
            3'd5: res = a & b;
            3'd6: res = a | b;
            default: begin full = a * b; res = full % modv; carry = int'(full >= modv); end
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int hold);
        int res, carry, lat, expLat, zero, sign;
        refModel(op, int'(a), int'(b), res, carry);
        zero   = int'(res == 0);
        sign   = (res >> (W - 1)) & 1;
        expLat = (op == 3'b111) ? W + 1 : 1;

        checkOutput("idleReady", 32'(bus.in_ready), 1);
        bus.A = a; bus.B = b; bus.OP = op; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.A = W'($urandom); bus.B = W'($urandom); bus.OP = 3'($urandom);

        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            checkOutput("busyReady", 32'(bus.in_ready), 0);
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", lat, expLat);
        checkOutput("outValid", 32'(bus.out_valid), 1);
        checkOutput("out", 32'(bus.out), res);
        checkOutput("carry", 32'(bus.Carry), carry);
        checkOutput("zero", 32'(bus.Zero), zero);
        checkOutput("sign", 32'(bus.Sign), sign);

        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.A = W'($urandom); bus.B = W'($urandom); bus.OP = 3'($urandom);
            @(posedge clk); #1;
            checkOutput("holdOut", 32'(bus.out), res);
            checkOutput("holdCarry", 32'(bus.Carry), carry);
            checkOutput("holdZero", 32'(bus.Zero), zero);
            checkOutput("holdValid", 32'(bus.out_valid), 1);
            checkOutput("holdReady", 32'(bus.in_ready), 0);
        end

        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checkOutput("releaseValid", 32'(bus.out_valid), 0);
        checkOutput("releaseReady", 32'(bus.in_ready), 1);
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.OP = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("rstOut", 32'(bus.out), 0);
        checkOutput("rstZero", 32'(bus.Zero), 1);
        checkOutput("rstSign", 32'(bus.Sign), 0);
        checkOutput("rstCarry", 32'(bus.Carry), 0);
        checkOutput("rstValid", 32'(bus.out_valid), 0);
        checkOutput("rstReady", 32'(bus.in_ready), 1);

        applyStimulus(3'b000, 8'hF0, 8'h20, 0);
        applyStimulus(3'b100, 8'h05, 8'h05, 0);
        applyStimulus(3'b100, 8'h03, 8'h05, 0);
        applyStimulus(3'b010, 8'h81, 8'd1, 0);
        applyStimulus(3'b001, 8'h81, 8'd9, 0);
        applyStimulus(3'b111, 8'h10, 8'h11, 0);
        applyStimulus(3'b111, 8'h07, 8'h06, 5);
        applyStimulus(3'b001, 8'h81, 8'd8, 0);
        applyStimulus(3'b010, 8'h81, 8'd8, 0);

        // Reset landing in the fourth BUSY cycle must discard the multiply.
        bus.A = 8'h07; bus.B = 8'h06; bus.OP = 3'b111; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("midRstValid", 32'(bus.out_valid), 0);
        checkOutput("midRstOut", 32'(bus.out), 0);
        checkOutput("midRstZero", 32'(bus.Zero), 1);
        checkOutput("midRstCarry", 32'(bus.Carry), 0);
        checkOutput("midRstReady", 32'(bus.in_ready), 1);
        applyStimulus(3'b011, 8'hAA, 8'hFF, 0);

        for (int n = 0; n < 60; n++) begin
            logic [2:0]   op;
            logic [W-1:0] a, b;
            op = 3'($urandom);
            a  = W'($urandom);
            b  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, W + 2)) : W'($urandom);
            applyStimulus(op, a, b, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
